// File: rtl/data_mem_io.sv
// Processor data-memory port: 240-byte RAM plus memory-mapped TX FIFO, RX holding
// register and free-running cycle counter with snapshot.
module data_mem_io #(
    parameter int unsigned TX_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       memWE,
    input  logic [7:0] addr,
    input  logic [7:0] writedata,
    output logic [7:0] databus,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready
);

    localparam int unsigned RAM_WORDS = 240;
    localparam int unsigned PTR_W     = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
    localparam int unsigned CNT_W     = $clog2(TX_DEPTH + 1);
    localparam int unsigned TICK_W    = 16;

    localparam logic [7:0] IO_BASE    = 8'hF0;
    localparam logic [7:0] ADDR_TXDAT = 8'hF0;
    localparam logic [7:0] ADDR_STAT  = 8'hF1;
    localparam logic [7:0] ADDR_RXDAT = 8'hF2;
    localparam logic [7:0] ADDR_CNTLO = 8'hF3;
    localparam logic [7:0] ADDR_CNTHI = 8'hF4;

    logic [7:0]        ram  [RAM_WORDS];
    logic [7:0]        fifo [TX_DEPTH];
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  count;
    logic              tx_ovf;
    logic              rx_full;
    logic [7:0]        rx_hold;
    logic [TICK_W-1:0] cycle_cnt;
    logic [TICK_W-1:0] snapshot;

    logic       is_ram;
    logic       ram_we;
    logic       tx_full;
    logic       tx_empty;
    logic       pop;
    logic       push_req;
    logic       push;
    logic       ovf_set;
    logic       ovf_clr;
    logic       rx_capture;
    logic       rx_ack;
    logic       snap_we;
    logic [7:0] status;

    // Address decode and FIFO/RX handshake qualifiers
    always_comb begin
        is_ram     = (addr < IO_BASE);
        ram_we     = memWE && is_ram && !reset;
        tx_full    = (count == CNT_W'(TX_DEPTH));
        tx_empty   = (count == CNT_W'(0));
        pop        = tx_valid && tx_ready;
        push_req   = memWE && (addr == ADDR_TXDAT);
        push       = push_req && (!tx_full || pop);
        ovf_set    = push_req && tx_full && !pop;
        ovf_clr    = memWE && (addr == ADDR_STAT) && writedata[3];
        rx_capture = rx_valid && rx_ready;
        rx_ack     = memWE && (addr == ADDR_RXDAT) && rx_full;
        snap_we    = memWE && (addr == ADDR_CNTLO);
        status     = {4'b0000, tx_ovf, rx_full, tx_empty, tx_full};
    end

    assign tx_valid = !tx_empty;
    assign tx_data  = fifo[head];
    assign rx_ready = !rx_full;

    // Storage arrays are never reset; only their write enables honour reset
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[addr] <= writedata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && push) begin
            fifo[tail] <= writedata;
        end
    end

    // TX FIFO pointers, occupancy and sticky overflow
    always_ff @(posedge clk) begin
        if (reset) begin
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            tx_ovf <= 1'b0;
        end else begin
            if (pop) begin
                head <= head + PTR_W'(1);
            end
            if (push) begin
                tail <= tail + PTR_W'(1);
            end
            if (push && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push) begin
                count <= count - CNT_W'(1);
            end
            if (ovf_set) begin
                tx_ovf <= 1'b1;
            end else if (ovf_clr) begin
                tx_ovf <= 1'b0;
            end
        end
    end

    // RX holding register; an ack only exists while full, so it never races a capture
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_full <= 1'b0;
            rx_hold <= 8'h00;
        end else if (rx_capture) begin
            rx_full <= 1'b1;
            rx_hold <= rx_data;
        end else if (rx_ack) begin
            rx_full <= 1'b0;
        end
    end

    // Free-running counter; the snapshot takes the pre-increment value
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt <= '0;
            snapshot  <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + TICK_W'(1);
            if (snap_we) begin
                snapshot <= cycle_cnt;
            end
        end
    end

    always_comb begin
        databus = 8'h00;
        if (is_ram) begin
            databus = ram[addr];
        end else begin
            case (addr)
                ADDR_STAT:  databus = status;
                ADDR_RXDAT: databus = rx_hold;
                ADDR_CNTLO: databus = snapshot[7:0];
                ADDR_CNTHI: databus = snapshot[15:8];
                default:    databus = 8'h00;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_io.sv
// Directed bench for data_mem_io; TX bytes are tracked through an expected-data queue.
module tb_data_mem_io;

    logic       clk;
    logic       reset;
    logic       memWE;
    logic [7:0] addr;
    logic [7:0] writedata;
    logic [7:0] databus;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    logic [7:0]  exp_q[$];

    data_mem_io #(.TX_DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .memWE     (memWE),
        .addr      (addr),
        .writedata (writedata),
        .databus   (databus),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string tag);
        memWE = 1'b0;
        addr  = a;
        #1;
        chk(tag, databus, exp);
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        memWE     = 1'b1;
        addr      = a;
        writedata = d;
        tick();
        memWE     = 1'b0;
    endtask

    task automatic push_tx(input logic [7:0] d);
        exp_q.push_back(d);
        wr(8'hF0, d);
    endtask

    // Expects one byte per cycle until the scoreboard is empty
    task automatic drain();
        tx_ready = 1'b1;
        while (exp_q.size() > 0) begin
            chk("tx_valid_drain", {7'b0, tx_valid}, 8'h01);
            chk("tx_data_drain", tx_data, exp_q.pop_front());
            tick();
        end
        chk("tx_valid_after_drain", {7'b0, tx_valid}, 8'h00);
    endtask

    initial begin
        reset     = 1'b1;
        memWE     = 1'b0;
        addr      = 8'h00;
        writedata = 8'h00;
        tx_ready  = 1'b0;
        rx_data   = 8'h00;
        rx_valid  = 1'b0;
        tick();
        tick();

        // Reset state
        chk("rst_tx_valid", {7'b0, tx_valid}, 8'h00);
        chk("rst_rx_ready", {7'b0, rx_ready}, 8'h01);
        rd(8'hF1, 8'h02, "rst_status");
        rd(8'hF3, 8'h00, "rst_cntlo");
        rd(8'hF2, 8'h00, "rst_rxdata");

        // Counter: snapshot taken on the 10th edge after release holds 9
        tick();
        reset = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        wr(8'hF3, 8'h00);
        rd(8'hF3, 8'h09, "cnt_lo");
        rd(8'hF4, 8'h00, "cnt_hi");

        // RAM and unmapped I/O
        wr(8'h10, 8'hA5);
        wr(8'hEF, 8'h5E);
        rd(8'h10, 8'hA5, "ram_10");
        rd(8'hEF, 8'h5E, "ram_ef");
        rd(8'hF7, 8'h00, "unmapped_f7");
        wr(8'hF7, 8'hFF);
        rd(8'hF7, 8'h00, "unmapped_f7_after_wr");
        rd(8'hF0, 8'h00, "txdata_read");

        // TX order, full and overflow
        tx_ready = 1'b0;
        for (int i = 1; i <= 4; i++) push_tx(8'(i));
        rd(8'hF1, 8'h01, "status_full");
        wr(8'hF0, 8'h05);
        rd(8'hF1, 8'h09, "status_ovf");
        tick();
        chk("tx_hold_stalled", tx_data, exp_q[0]);
        drain();
        rd(8'hF1, 8'h0A, "status_empty_ovf");
        wr(8'hF1, 8'h08);
        rd(8'hF1, 8'h02, "status_ovf_cleared");

        // Full FIFO with simultaneous push and pop
        tx_ready = 1'b0;
        for (int i = 1; i <= 4; i++) push_tx(8'(8'h11 * i));
        tx_ready = 1'b1;
        chk("simul_pop_data", tx_data, exp_q.pop_front());
        exp_q.push_back(8'h55);
        wr(8'hF0, 8'h55);
        tx_ready = 1'b0;
        rd(8'hF1, 8'h01, "simul_still_full_no_ovf");
        drain();
        rd(8'hF1, 8'h02, "simul_status_empty");

        // RX capture, hold while full, acknowledge
        rx_data  = 8'h3C;
        rx_valid = 1'b1;
        chk("rx_ready_idle", {7'b0, rx_ready}, 8'h01);
        tick();
        rx_data  = 8'h77;
        chk("rx_ready_full", {7'b0, rx_ready}, 8'h00);
        rd(8'hF1, 8'h06, "status_rx_full");
        rd(8'hF2, 8'h3C, "rx_data_held");
        tick();
        rx_valid = 1'b0;
        rd(8'hF2, 8'h3C, "rx_no_overwrite");
        wr(8'hF2, 8'h00);
        chk("rx_ready_acked", {7'b0, rx_ready}, 8'h01);
        rd(8'hF1, 8'h02, "status_rx_acked");
        rx_data  = 8'h5A;
        rx_valid = 1'b1;
        wr(8'hF2, 8'h00);
        rx_valid = 1'b0;
        chk("rx_ack_empty_capture", {7'b0, rx_ready}, 8'h00);
        rd(8'hF2, 8'h5A, "rx_capture_with_ack");

        // Snapshot unchanged by time passing
        for (int i = 0; i < 5; i++) tick();
        rd(8'hF3, 8'h09, "cnt_lo_stable");
        rd(8'hF4, 8'h00, "cnt_hi_stable");

        // Reset mid-operation, with a push pending in the reset cycle
        tx_ready = 1'b0;
        push_tx(8'hAA);
        push_tx(8'hBB);
        chk("pre_reset_tx_valid", {7'b0, tx_valid}, 8'h01);
        reset     = 1'b1;
        memWE     = 1'b1;
        addr      = 8'hF0;
        writedata = 8'hCC;
        tx_ready  = 1'b1;
        tick();
        reset    = 1'b0;
        memWE    = 1'b0;
        tx_ready = 1'b0;
        exp_q.delete();
        chk("mid_rst_tx_valid", {7'b0, tx_valid}, 8'h00);
        chk("mid_rst_rx_ready", {7'b0, rx_ready}, 8'h01);
        rd(8'hF1, 8'h02, "mid_rst_status");
        rd(8'hF2, 8'h00, "mid_rst_rxdata");
        rd(8'hF3, 8'h00, "mid_rst_cntlo");
        rd(8'h10, 8'hA5, "ram_survives_reset");
        push_tx(8'h77);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/data_mem_io.md
DATA_MEM_IO -- requirements
Module: data_mem_io

Interface
REQ-001 SHALL have one clock, clk; reset is synchronous and active-high, named reset.
REQ-002 SHALL have ports as follows, with clock and reset first:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high
- memWE  in  1  processor store strobe
- addr  in  8  byte address (processor aluout)
- writedata  in  8  store data
- databus  out  8  load data to processor, combinational
- tx_data  out  8  TX FIFO head byte
- tx_valid  out  1  TX FIFO non-empty
- tx_ready  in  1  sink accepts tx_data
- rx_data  in  8  incoming byte
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  block can accept a byte
REQ-003 SHALL have parameter TX_DEPTH, default 4 (power of 2), giving the TX FIFO entry count.

Function
REQ-004 SHALL map 0x00-0xEF to a 240x8 RAM: asynchronous read, write on rising clk when memWE=1.
REQ-005 SHALL map the following I/O addresses:
- 0xF0 TXDATA: write pushes.
- 0xF1 STATUS: read {4'b0, tx_ovf, rx_full, tx_empty, tx_full}; a write with writedata[3]=1 clears tx_ovf.
- 0xF2 RXDATA: read returns the holding register; any write acknowledges it (clears rx_full).
- 0xF3 CNTLO: read returns snapshot[7:0]; any write latches the counter into the snapshot.
- 0xF4 CNTHI: read returns snapshot[15:8].
REQ-006 SHALL return 0x00 on reads of 0xF5-0xFF and ignore writes there.
REQ-007 SHALL make databus purely combinational from addr and current state; reads have no side effects.
REQ-008 SHALL implement the TX FIFO with head/tail pointers of log2(TX_DEPTH) bits wrapping modulo TX_DEPTH, plus a count of 0..TX_DEPTH.
REQ-009 SHALL define tx_valid = (count!=0), tx_data = entry[head], tx_full = (count==TX_DEPTH), tx_empty = (count==0).
REQ-010 SHALL pop when tx_valid && tx_ready: head+1, count-1.
REQ-011 SHALL accept a push when memWE && addr==0xF0 && (!tx_full || pop this cycle): write at tail, tail+1.
REQ-012 SHALL, on a simultaneous accepted push and pop, leave count unchanged.
REQ-013 SHALL, on a push while full with no pop, drop the byte, leave pointers and count unchanged, and set sticky tx_ovf=1.
REQ-014 SHALL let set win if a tx_ovf set and clear occur in the same cycle.
REQ-015 SHALL hold tx_data stable while tx_valid && !tx_ready.
REQ-016 SHALL drive rx_ready = !rx_full; on rx_valid && rx_ready, capture rx_data into the holding register and set rx_full=1 next cycle.
REQ-017 SHALL clear rx_full on a write to 0xF2 when rx_full=1; with rx_full=0 such a write has no effect, and a same-cycle capture proceeds.
REQ-018 SHALL have a 16-bit free-running cycle counter, +1 every non-reset cycle, wrapping 0xFFFF->0x0000.
REQ-019 SHALL, on a write to 0xF3, load the snapshot with the counter value before that edge's increment.
REQ-020 SHALL give one-cycle effect latency for all writes: state is visible on databus the cycle after the store edge.

Reset
REQ-021 SHALL, at a rising clk with reset=1, set:
- TX head, tail and count to 0, and tx_ovf=0;
- rx_full=0 and the holding register to 0x00;
- counter and snapshot to 0x0000.
REQ-022 SHALL not clear RAM or FIFO storage on reset; contents are undefined until written.
REQ-023 SHALL make reset dominant over all writes, pushes, pops and captures in the same cycle.
REQ-024 SHALL, after reset, output tx_valid=0 and rx_ready=1.
REQ-025 SHALL abort an in-progress TX handshake on reset mid-transfer: the stalled byte is discarded.

Verification
REQ-026 SHALL cover these directed scenarios:
- RAM: store 0xA5 to 0x10, then read 0x10 -> databus=0xA5; read 0xF7 -> 0x00.
- TX order/full: tx_ready=0; push 0x01..0x04 -> STATUS=0x01. Push 0x05 -> dropped, STATUS=0x09. Set tx_ready=1 -> tx_data 0x01,0x02,0x03,0x04 on consecutive cycles, then tx_valid=0 and STATUS=0x0A. Write 0x08 to 0xF1 -> STATUS=0x02.
- Full with simultaneous push/pop: FIFO full, tx_ready=1, push 0x55 -> count stays 4, no overflow, 0x55 emerges fourth.
- RX: rx_valid=1, rx_data=0x3C -> next cycle rx_ready=0, STATUS bit2=1, read 0xF2 -> 0x3C. Write 0xF2 -> rx_ready=1.
- Counter: 10 cycles after reset release, write 0xF3 -> CNTLO=0x09, CNTHI=0x00. Snapshot stays stable on later cycles.
- Reset mid-operation: FIFO holding 2 bytes, rx_full=1, reset=1 for one cycle -> tx_valid=0, rx_ready=1, STATUS=0x02.
